// File: rtl/fast_control_pkg.sv
// rtl/fast_control_pkg.sv - shared fast-control word format and lock FSM states
package fast_control_pkg;

    localparam logic [3:0]  FC_HEADER         = 4'hA;
    localparam logic [15:0] FC_IDLE_WORD      = {FC_HEADER, 12'h000};

    localparam int          FC_BIT_L1A        = 11;
    localparam int          FC_BIT_BCR        = 10;
    localparam int          FC_BIT_OCR        = 9;
    localparam int          FC_BIT_CALIB      = 8;
    localparam int          FC_BIT_LINK_RESET = 7;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_SYNCING  = 2'd1,
        ST_LOCKED   = 2'd2
    } fc_state_t;

    // Good word: correct header nibble and even parity over all 16 bits.
    function automatic logic fc_word_good(input logic [15:0] word);
        return (word[15:12] == FC_IDLE_WORD[15:12]) && !(^word);
    endfunction

endpackage

// File: rtl/fc_lock_fsm.sv
// rtl/fc_lock_fsm.sv - link lock FSM with consecutive good/bad word counters
module fc_lock_fsm
    import fast_control_pkg::*;
#(
    parameter int LOCK_COUNT   = 16,
    parameter int UNLOCK_COUNT = 4
) (
    input  logic      clk_link,
    input  logic      reset_n,
    input  logic      word_good,
    output fc_state_t state,
    output logic      accept,
    output logic      bad_locked,
    output logic      unlock_evt
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(UNLOCK_COUNT + 1);

    fc_state_t       state_nxt;
    logic [GW-1:0]   good_cnt, good_cnt_nxt;
    logic [BW-1:0]   bad_cnt, bad_cnt_nxt;

    always_ff @(posedge clk_link or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_UNLOCKED;
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_cnt_nxt;
            bad_cnt  <= bad_cnt_nxt;
        end
    end

    // accept marks a good word whose commands are honoured, including the lock-completing one.
    always_comb begin
        state_nxt    = state;
        good_cnt_nxt = good_cnt;
        bad_cnt_nxt  = bad_cnt;
        accept       = 1'b0;
        bad_locked   = 1'b0;
        unlock_evt   = 1'b0;
        case (state)
            ST_UNLOCKED: begin
                if (word_good) begin
                    if (LOCK_COUNT <= 1) begin
                        state_nxt    = ST_LOCKED;
                        good_cnt_nxt = '0;
                        accept       = 1'b1;
                    end else begin
                        state_nxt    = ST_SYNCING;
                        good_cnt_nxt = GW'(1);
                    end
                end
            end
            ST_SYNCING: begin
                if (!word_good) begin
                    state_nxt    = ST_UNLOCKED;
                    good_cnt_nxt = '0;
                end else if (good_cnt == GW'(LOCK_COUNT - 1)) begin
                    state_nxt    = ST_LOCKED;
                    good_cnt_nxt = '0;
                    accept       = 1'b1;
                end else begin
                    good_cnt_nxt = good_cnt + 1'b1;
                end
            end
            ST_LOCKED: begin
                if (word_good) begin
                    accept      = 1'b1;
                    bad_cnt_nxt = '0;
                end else begin
                    bad_locked = 1'b1;
                    if (bad_cnt == BW'(UNLOCK_COUNT - 1)) begin
                        state_nxt   = ST_UNLOCKED;
                        bad_cnt_nxt = '0;
                        unlock_evt  = 1'b1;
                    end else begin
                        bad_cnt_nxt = bad_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt    = ST_UNLOCKED;
                good_cnt_nxt = '0;
                bad_cnt_nxt  = '0;
            end
        endcase
    end

endmodule

// File: rtl/fast_control_decoder.sv
// rtl/fast_control_decoder.sv - fast-control decoder with BX/orbit counters; FC_DECODER_ERRCNT_EN adds error counters
module fast_control_decoder
    import fast_control_pkg::*;
#(
    parameter int LOCK_COUNT   = 16,
    parameter int UNLOCK_COUNT = 4,
    parameter int BX_PER_ORBIT = 3564
) (
    input  logic        clk_link,
    input  logic        reset_n,
    input  logic [15:0] fc_stream_enc,
    output logic        locked,
    output logic        l1a,
    output logic        bcr,
    output logic        ocr,
    output logic        calib,
    output logic        link_reset,
    output logic        cmd_err,
    output logic [11:0] bx_count,
`ifdef FC_DECODER_ERRCNT_EN
    output logic [15:0] err_count,
    output logic [7:0]  unlock_count,
`endif
    output logic [23:0] orbit_count
);

    localparam logic [11:0] BX_LAST = 12'(BX_PER_ORBIT - 1);

    fc_state_t   state;
    logic        word_good;
    logic        accept;
    logic        bad_locked;
    logic        l1a_nxt, bcr_nxt, ocr_nxt, calib_nxt, link_reset_nxt;
    logic [11:0] bx_nxt;
    logic [23:0] orbit_nxt;
`ifdef FC_DECODER_ERRCNT_EN
    logic        unlock_evt;
`endif

    assign word_good = fc_word_good(fc_stream_enc);

    fc_lock_fsm #(
        .LOCK_COUNT   (LOCK_COUNT),
        .UNLOCK_COUNT (UNLOCK_COUNT)
    ) u_lock_fsm (
        .clk_link   (clk_link),
        .reset_n    (reset_n),
        .word_good  (word_good),
        .state      (state),
        .accept     (accept),
        .bad_locked (bad_locked),
`ifdef FC_DECODER_ERRCNT_EN
        .unlock_evt (unlock_evt)
`else
        .unlock_evt ()
`endif
    );

    assign locked = (state == ST_LOCKED);

    assign l1a_nxt        = accept & fc_stream_enc[FC_BIT_L1A];
    assign bcr_nxt        = accept & fc_stream_enc[FC_BIT_BCR];
    assign ocr_nxt        = accept & fc_stream_enc[FC_BIT_OCR];
    assign calib_nxt      = accept & fc_stream_enc[FC_BIT_CALIB];
    assign link_reset_nxt = accept & fc_stream_enc[FC_BIT_LINK_RESET];

    // Counters update on the same edge the pulses register, so bcr/ocr and the zeroed count coincide.
    always_comb begin
        bx_nxt    = bx_count;
        orbit_nxt = orbit_count;
        if (locked) begin
            if (bx_count == BX_LAST) begin
                bx_nxt    = '0;
                orbit_nxt = orbit_count + 1'b1;
            end else begin
                bx_nxt = bx_count + 1'b1;
            end
        end
        if (bcr_nxt) begin
            bx_nxt = '0;
        end
        if (ocr_nxt) begin
            orbit_nxt = '0;
        end
    end

    always_ff @(posedge clk_link or negedge reset_n) begin
        if (!reset_n) begin
            l1a         <= 1'b0;
            bcr         <= 1'b0;
            ocr         <= 1'b0;
            calib       <= 1'b0;
            link_reset  <= 1'b0;
            cmd_err     <= 1'b0;
            bx_count    <= '0;
            orbit_count <= '0;
        end else begin
            l1a         <= l1a_nxt;
            bcr         <= bcr_nxt;
            ocr         <= ocr_nxt;
            calib       <= calib_nxt;
            link_reset  <= link_reset_nxt;
            cmd_err     <= bad_locked;
            bx_count    <= bx_nxt;
            orbit_count <= orbit_nxt;
        end
    end

`ifdef FC_DECODER_ERRCNT_EN
    always_ff @(posedge clk_link or negedge reset_n) begin
        if (!reset_n) begin
            err_count    <= '0;
            unlock_count <= '0;
        end else if (link_reset_nxt) begin
            err_count    <= '0;
            unlock_count <= '0;
        end else begin
            if (bad_locked && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
            if (unlock_evt && (unlock_count != '1)) begin
                unlock_count <= unlock_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fast_control_decoder.sv
// tb/tb_fast_control_decoder.sv - scoreboard bench for fast_control_decoder
module tb_fast_control_decoder;

    logic        clk_link = 1'b0;
    logic        reset_n  = 1'b0;
    logic [15:0] fc_stream_enc = 16'hA000;
    logic        locked, l1a, bcr, ocr, calib, link_reset, cmd_err;
    logic [11:0] bx_count;
    logic [23:0] orbit_count;
`ifdef FC_DECODER_ERRCNT_EN
    logic [15:0] err_count;
    logic [7:0]  unlock_count;
`endif

    fast_control_decoder dut (
        .clk_link      (clk_link),
        .reset_n       (reset_n),
        .fc_stream_enc (fc_stream_enc),
        .locked        (locked),
        .l1a           (l1a),
        .bcr           (bcr),
        .ocr           (ocr),
        .calib         (calib),
        .link_reset    (link_reset),
        .cmd_err       (cmd_err),
        .bx_count      (bx_count),
`ifdef FC_DECODER_ERRCNT_EN
        .err_count     (err_count),
        .unlock_count  (unlock_count),
`endif
        .orbit_count   (orbit_count)
    );

    always #5 clk_link = ~clk_link;

    localparam logic [5:0] P_L1A = 6'b100000;
    localparam logic [5:0] P_BCR = 6'b010000;
    localparam logic [5:0] P_OCR = 6'b001000;
    localparam logic [5:0] P_CAL = 6'b000100;
    localparam logic [5:0] P_LR  = 6'b000010;
    localparam logic [5:0] P_ERR = 6'b000001;

    typedef struct packed {
        logic [5:0]  pulses;
        logic        lock;
        logic [11:0] bx;
        logic [23:0] orbit;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_vec = 0;
    int         n_err = 0;
    logic [5:0] pulses_w;

    assign pulses_w = {l1a, bcr, ocr, calib, link_reset, cmd_err};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Drive at a falling edge; return at the next falling edge with the response visible.
    task automatic tick(input logic [15:0] w);
        fc_stream_enc = w;
        @(negedge clk_link);
    endtask

    task automatic tick_exp(input logic [15:0] w, input logic [5:0] p, input logic lk,
                            input logic [11:0] bx, input logic [23:0] orb);
        exp_t e;
        e.pulses = p;
        e.lock   = lk;
        e.bx     = bx;
        e.orbit  = orb;
        exp_q.push_back(e);
        tick(w);
    endtask

    always @(negedge clk_link) begin
        if (reset_n && (pulses_w != 6'b0)) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pulse: got %b required none", pulses_w);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulses", 64'(pulses_w), 64'(mon_e.pulses));
                check("pulse_locked", 64'(locked), 64'(mon_e.lock));
                check("pulse_bx", 64'(bx_count), 64'(mon_e.bx));
                check("pulse_orbit", 64'(orbit_count), 64'(mon_e.orbit));
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk_link);
        check("reset_outputs", 64'({locked, pulses_w, bx_count, orbit_count}), 64'(0));
        reset_n = 1'b1;

        repeat (15) tick(16'hA000);
        check("locked_after_15", 64'(locked), 64'(0));
        tick(16'hA000);
        check("locked_after_16", 64'(locked), 64'(1));
        check("bx_at_lock", 64'(bx_count), 64'(0));

        tick_exp(16'hA801, P_L1A, 1'b1, 12'd1, 24'd0);
        tick(16'hA000);
        tick_exp(16'hAC00, P_L1A | P_BCR, 1'b1, 12'd0, 24'd0);

        repeat (3562) tick(16'hA000);
        tick(16'hA000);
        check("bx_at_last", 64'(bx_count), 64'(3563));
        check("orbit_before_wrap", 64'(orbit_count), 64'(0));
        tick(16'hA000);
        check("bx_after_wrap", 64'(bx_count), 64'(0));
        check("orbit_after_wrap", 64'(orbit_count), 64'(1));

        repeat (3563) tick(16'hA000);
        check("bx_at_last_2", 64'(bx_count), 64'(3563));
        tick_exp(16'hA401, P_BCR, 1'b1, 12'd0, 24'd2);
        tick(16'hA000);
        check("bx_after_bcr_wrap", 64'(bx_count), 64'(1));
        check("orbit_after_bcr_wrap", 64'(orbit_count), 64'(2));

        tick_exp(16'hA201, P_OCR, 1'b1, 12'd2, 24'd0);
        tick_exp(16'hA180, P_CAL | P_LR, 1'b1, 12'd3, 24'd0);

        for (int i = 0; i < 3; i++) tick_exp(16'hA800, P_ERR, 1'b1, 12'(4 + i), 24'd0);
        tick(16'hA000);
        check("locked_after_3_bad", 64'(locked), 64'(1));
        check("bx_after_3_bad", 64'(bx_count), 64'(7));

        for (int i = 0; i < 4; i++) tick_exp(16'hA800, P_ERR, (i < 3), 12'(8 + i), 24'd0);
        tick(16'hA000);
        check("locked_after_4_bad", 64'(locked), 64'(0));
        check("bx_frozen", 64'(bx_count), 64'(11));
`ifdef FC_DECODER_ERRCNT_EN
        check("err_count", 64'(err_count), 64'(7));
        check("unlock_count", 64'(unlock_count), 64'(1));
`endif

        repeat (14) tick(16'hA000);
        check("relock_pending", 64'(locked), 64'(0));
        tick(16'hA000);
        check("relocked", 64'(locked), 64'(1));

        fc_stream_enc = 16'hA801;
        @(posedge clk_link);
        #1;
        check("l1a_before_reset", 64'(l1a), 64'(1));
        reset_n = 1'b0;
        #1;
        check("outputs_in_reset", 64'({locked, pulses_w, bx_count, orbit_count}), 64'(0));
        @(negedge clk_link);
        @(negedge clk_link);
        fc_stream_enc = 16'hA000;
        reset_n = 1'b1;
        repeat (15) tick(16'hA000);
        check("locked_15_after_reset", 64'(locked), 64'(0));
        tick(16'hA000);
        check("locked_16_after_reset", 64'(locked), 64'(1));

        repeat (2) @(negedge clk_link);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fast_control_decoder.md
FAST_CONTROL_DECODER -- requirements
Module: fast_control_decoder

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 16: consecutive good words needed to lock.
REQ-002 SHALL have parameter UNLOCK_COUNT, default 4: consecutive bad words while locked needed to unlock.
REQ-003 SHALL have parameter BX_PER_ORBIT, default 3564: bunch crossings per orbit.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 SHALL have ports:
- clk_link  in  1: link clock, one encoded word per cycle.
- reset_n  in  1: asynchronous active-low reset.
- fc_stream_enc  in  16: encoded fast-control word.
- locked  out  1: decoder locked.
- l1a, bcr, ocr, calib, link_reset  out  1 each: single-cycle command pulses.
- cmd_err  out  1: pulse on each bad word while locked.
- bx_count  out  12: bunch-crossing counter.
- orbit_count  out  24: orbit counter.

Function
REQ-006 SHALL treat a word as good when bits[15:12]=4'hA and the 16-bit word has even parity; bit[0] is the parity bit.
REQ-007 SHALL use command flags [11]=L1A, [10]=BCR, [9]=OCR, [8]=CALIB, [7]=LINK_RESET, ignore bits[6:1], and accept multiple flags in one word; 16'hA000 is idle.
REQ-008 SHALL implement FSM states UNLOCKED, SYNCING and LOCKED.
- UNLOCKED goes to SYNCING on a good word.
- SYNCING goes to LOCKED after LOCK_COUNT consecutive good words.
- SYNCING goes back to UNLOCKED on any bad word.
- LOCKED goes to UNLOCKED after UNLOCK_COUNT consecutive bad words; a good word clears the bad-word count.
REQ-009 SHALL drive locked high exactly while in LOCKED.
REQ-010 SHALL sample fc_stream_enc at edge k and assert the command pulses for exactly one cycle starting at edge k+1 (latency 1).
REQ-011 SHALL emit command pulses only for good words received while LOCKED, including the word that completes the lock count.
REQ-012 SHALL assert cmd_err one cycle after each bad word received in LOCKED, including the word that causes unlock.
REQ-013 SHALL increment bx_count once per cycle while locked.
- Wrap from BX_PER_ORBIT-1 to 0 and increment orbit_count by 1 on wrap.
- orbit_count wraps modulo 2^24.
REQ-014 SHALL set bx_count to 0 in the cycle bcr is high.
- BCR does not increment orbit_count.
- BCR coincident with a wrap still increments orbit_count exactly once.
REQ-015 SHALL set orbit_count to 0 in the cycle ocr is high; OCR has priority over a coincident orbit increment.
REQ-016 SHALL hold bx_count and orbit_count while not locked, and resume counting from the held values on relock.

Reset
REQ-017 SHALL, while reset_n is low, force the FSM to UNLOCKED and clear all counters and outputs to 0, asynchronously.
REQ-018 SHALL deassert any in-flight pulse immediately when reset asserts mid-operation, and SHALL start the lock sequence from zero after release.

Configuration
REQ-019 SHALL, with macro FC_DECODER_ERRCNT_EN defined, add the following, both cleared by reset and by link_reset:
- Output err_count (16 bits, saturating): counts bad words received in LOCKED.
- Output unlock_count (8 bits, saturating): counts LOCKED to UNLOCKED transitions.
REQ-020 SHALL, without FC_DECODER_ERRCNT_EN, omit those ports and their logic entirely.

Structure
REQ-021 SHALL take the header nibble, flag bit positions, idle word and FSM state enumeration from shared package fast_control_pkg, which the encoder also uses.
REQ-022 SHALL place the lock FSM and its good/bad counters in sub-module fc_lock_fsm.
REQ-023 SHALL keep command decode and the BX/orbit counters in the top module.

Verification
REQ-024 SHALL cover lock-up: 16 x 16'hA000 after reset, then locked rises one cycle after the 16th word, with no pulses and no cmd_err.
REQ-025 SHALL cover single L1A: when locked, 16'hA801 gives l1a high for exactly one cycle, one cycle later, with all other pulses low.
REQ-026 SHALL cover combined commands: 16'hAC00 gives l1a and bcr in the same cycle and bx_count=0 in that cycle; 16'hA201 gives ocr and orbit_count=0.
REQ-027 SHALL cover orbit wrap: bx_count reaches 3563, then next cycle bx_count=0 and orbit_count increments by 1; BCR injected on that same cycle still gives exactly one orbit increment.
REQ-028 SHALL cover loss of lock:
- When locked, 3 bad-parity words (16'hA800) then 16'hA000 keeps locked and gives 3 cmd_err pulses.
- 4 consecutive bad words drop locked and freeze bx_count.
- With FC_DECODER_ERRCNT_EN, err_count=7 and unlock_count=1.
REQ-029 SHALL cover mid-operation reset: reset_n asserted during an l1a pulse clears all outputs immediately; after release, 15 good words leave locked=0.
